// File: rtl/vpi_pkg.sv
// Shared types and LFSR step for the VPI public-signal pattern source.
package vpi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    ACKED,
    DONE
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // 32-bit Galois LFSR, right shift.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/vpi_lfsr32.sv
// 32-bit LFSR state register that steps only when strobed.
module vpi_lfsr32
  import vpi_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_advance,
  output logic [31:0] o_state
);

  // An all-zero state would lock up the LFSR.
  localparam logic [31:0] SEED_EFF = (SEED == '0) ? 32'h0000_0001 : SEED;

  logic [31:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED_EFF;
    end else if (i_advance) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/vpi_pattern_source.sv
// Pattern-word producer with four-phase ack handshake, transfer count,
// protocol-violation and ack-timeout flags.
module vpi_pattern_source
  import vpi_pkg::*;
#(
  parameter int unsigned LENGTH    = 8,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int unsigned COUNT_MAX = 16,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              enable,
  input  logic              ack,
  output logic [LENGTH-1:0] sig,
  output logic              valid,
  output logic [31:0]       count,
  output logic              done,
  output logic              err_proto,
  output logic              err_timeout
);

  localparam logic [31:0] TIMER_LIM = 32'(TIMEOUT - 1);
  localparam logic [31:0] COUNT_LIM = 32'(COUNT_MAX);

  state_t      r_state;
  logic        r_valid;
  logic [31:0] r_count;
  logic        r_done;
  logic        r_err_proto;
  logic        r_err_timeout;
  logic [31:0] r_timer;

  logic        w_advance;
  logic [31:0] w_lfsr;

  // LFSR steps exactly on the ACKED exit, in the same cycle the FSM leaves.
  assign w_advance = (r_state == ACKED) && !ack;

  vpi_lfsr32 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (reset_l),
    .i_advance (w_advance),
    .o_state   (w_lfsr)
  );

  // sig is a pure rewiring of the LFSR register: replicate, then truncate.
  assign sig = LENGTH'({4{w_lfsr}});

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state       <= IDLE;
      r_valid       <= 1'b0;
      r_count       <= '0;
      r_done        <= 1'b0;
      r_err_proto   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_timer       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ack) begin
            r_err_proto <= 1'b1;
          end else if (enable && !r_done) begin
            r_state <= PRESENT;
            r_valid <= 1'b1;
          end
        end
        PRESENT: begin
          if (ack) begin
            r_state <= ACKED;
            r_valid <= 1'b0;
            r_count <= r_count + 32'd1;
            r_timer <= '0;
          end else begin
            if (r_timer >= TIMER_LIM) begin
              r_err_timeout <= 1'b1;
            end
            if (r_timer != '1) begin
              r_timer <= r_timer + 32'd1;
            end
          end
        end
        ACKED: begin
          if (!ack) begin
            if (r_count == COUNT_LIM) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (enable) begin
              r_state <= PRESENT;
              r_valid <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        DONE: begin
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign valid       = r_valid;
  assign count       = r_count;
  assign done        = r_done;
  assign err_proto   = r_err_proto;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_vpi_pattern_source.sv
// Directed bench for vpi_pattern_source with a scoreboard of expected LFSR words.
module tb_vpi_pattern_source;

  logic        clk;
  logic        reset_l;
  logic        enable;
  logic        ack;

  logic [7:0]  sig8;
  logic        valid8;
  logic [31:0] count8;
  logic        done8;
  logic        eproto8;
  logic        eto8;

  logic [39:0] sig40;
  logic        valid40;
  logic [31:0] count40;
  logic        done40;
  logic        eproto40;
  logic        eto40;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m;

  vpi_pattern_source #(
    .LENGTH    (8),
    .SEED      (32'h0000_0001),
    .COUNT_MAX (3),
    .TIMEOUT   (10)
  ) u_dut8 (
    .clk         (clk),
    .reset_l     (reset_l),
    .enable      (enable),
    .ack         (ack),
    .sig         (sig8),
    .valid       (valid8),
    .count       (count8),
    .done        (done8),
    .err_proto   (eproto8),
    .err_timeout (eto8)
  );

  vpi_pattern_source #(
    .LENGTH    (40),
    .SEED      (32'h0000_0001),
    .COUNT_MAX (3),
    .TIMEOUT   (10)
  ) u_dut40 (
    .clk         (clk),
    .reset_l     (reset_l),
    .enable      (enable),
    .ack         (ack),
    .sig         (sig40),
    .valid       (valid40),
    .count       (count40),
    .done        (done40),
    .err_proto   (eproto40),
    .err_timeout (eto40)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] m_next(input logic [31:0] s);
    logic [31:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 32'h8020_0003;
    return t;
  endfunction

  function automatic logic [63:0] m_pat(input logic [31:0] s, input int len);
    logic [63:0] r;
    r = {s, s};
    return r & ((64'd1 << len) - 64'd1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_word(input string tag);
    logic [31:0] s;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=word", tag);
    end
    if (exp_q.size() != 0) begin
      s = exp_q.pop_front();
      chk({tag, "_sig8"}, 64'(sig8), m_pat(s, 8));
      chk({tag, "_sig40"}, 64'(sig40), m_pat(s, 40));
      chk({tag, "_v40"}, 64'(valid40), 64'd1);
    end
  endtask

  initial begin
    reset_l = 1'b0;
    enable  = 1'b0;
    ack     = 1'b0;
    m       = 32'h0000_0001;
    step;
    step;
    chk("rst_valid", 64'(valid8), 64'd0);
    chk("rst_count", 64'(count8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_eproto", 64'(eproto8), 64'd0);
    chk("rst_eto", 64'(eto8), 64'd0);
    chk("rst_sig8", 64'(sig8), 64'h01);
    chk("rst_sig40", 64'(sig40), 64'h01_0000_0001);

    reset_l = 1'b1;
    step;
    chk("idle_valid", 64'(valid8), 64'd0);

    // Phase A: handshakes, timeout boundary, completion.
    enable = 1'b1;
    exp_q.push_back(m);
    step;
    chk("en_lat", 64'(valid8), 64'd1);
    pop_word("w1");
    chk("w1_sig8", 64'(sig8), 64'h01);

    ack = 1'b1;
    step;
    chk("ack_lat", 64'(valid8), 64'd0);
    chk("cnt1", 64'(count8), 64'd1);

    ack = 1'b0;
    m = m_next(m);
    exp_q.push_back(m);
    step;
    chk("rel_lat", 64'(valid8), 64'd1);
    pop_word("w2");
    chk("w2_sig8", 64'(sig8), 64'h03);
    chk("w2_sig40", 64'(sig40), 64'h03_8020_0003);

    repeat (9) step;
    chk("to_early", 64'(eto8), 64'd0);
    step;
    chk("to_set", 64'(eto8), 64'd1);
    chk("to_set40", 64'(eto40), 64'd1);
    chk("to_valid", 64'(valid8), 64'd1);

    ack = 1'b1;
    step;
    chk("late_cnt", 64'(count8), 64'd2);
    chk("to_sticky", 64'(eto8), 64'd1);

    ack = 1'b0;
    m = m_next(m);
    exp_q.push_back(m);
    step;
    chk("w3_valid", 64'(valid8), 64'd1);
    pop_word("w3");

    ack = 1'b1;
    step;
    chk("cnt3", 64'(count8), 64'd3);
    ack = 1'b0;
    m = m_next(m);
    step;
    chk("done_set", 64'(done8), 64'd1);
    chk("done_valid", 64'(valid8), 64'd0);

    repeat (2) begin
      ack = 1'b1;
      step;
      ack = 1'b0;
      step;
    end
    chk("done_cnt", 64'(count8), 64'd3);
    chk("done_eproto", 64'(eproto8), 64'd0);
    chk("done_valid2", 64'(valid8), 64'd0);
    chk("done_sticky", 64'(done8), 64'd1);

    // Phase B: asynchronous reset while a word is presented.
    reset_l = 1'b0;
    step;
    reset_l = 1'b1;
    m = 32'h0000_0001;
    exp_q.push_back(m);
    step;
    chk("b1_valid", 64'(valid8), 64'd1);
    pop_word("b1");
    ack = 1'b1;
    step;
    ack = 1'b0;
    m = m_next(m);
    exp_q.push_back(m);
    step;
    chk("b2_valid", 64'(valid8), 64'd1);
    chk("b2_cnt", 64'(count8), 64'd1);
    pop_word("b2");

    reset_l = 1'b0;
    #1;
    chk("ar_valid", 64'(valid8), 64'd0);
    chk("ar_count", 64'(count8), 64'd0);
    chk("ar_sig8", 64'(sig8), 64'h01);
    chk("ar_sig40", 64'(sig40), 64'h01_0000_0001);
    chk("ar_done", 64'(done8), 64'd0);
    step;
    enable  = 1'b0;
    reset_l = 1'b1;
    m = 32'h0000_0001;
    step;

    // Phase C: protocol error in IDLE, restart from seed, enable gating.
    ack = 1'b1;
    step;
    chk("ep_set", 64'(eproto8), 64'd1);
    chk("ep_valid", 64'(valid8), 64'd0);
    ack = 1'b0;
    step;
    chk("ep_sticky", 64'(eproto8), 64'd1);

    enable = 1'b1;
    exp_q.push_back(m);
    step;
    chk("c1_valid", 64'(valid8), 64'd1);
    pop_word("c1");

    ack = 1'b1;
    step;
    chk("c1_cnt", 64'(count8), 64'd1);
    enable = 1'b0;
    ack    = 1'b0;
    m = m_next(m);
    step;
    chk("blk_valid", 64'(valid8), 64'd0);
    step;
    chk("blk_valid2", 64'(valid8), 64'd0);

    enable = 1'b1;
    exp_q.push_back(m);
    step;
    chk("c2_valid", 64'(valid8), 64'd1);
    pop_word("c2");
    chk("c2_cnt", 64'(count8), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vpi_pattern_source.md
Name: vpi_pattern_source

Overview:
- Producer end of the host-to-RTL public-signal check path. Generates pseudo-random pattern words in RTL and presents them in `verilator public_flat_rd` registers.
- The C side reads the words through VPI and acknowledges each one by writing a `public_flat_rw` ack bit. The block counts transfers, detects protocol violations and flags ack timeouts.
- Instantiated once per width under a generate loop in the test top, LENGTH 1..128.

Parameters:
- LENGTH, 8, pattern width in bits (1..128).
- SEED, 32'h0000_0001, initial LFSR state; value 0 is replaced by 1.
- COUNT_MAX, 16, number of words to deliver before asserting done.
- TIMEOUT, 1000, cycles in PRESENT without ack before err_timeout is set.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_l  in  1  reset, asynchronous and active-low.
- enable  in  1  permits starting or continuing the sequence.
- ack  in  1  host acknowledge, four-phase, written via VPI.
- sig  out  LENGTH  current pattern word (public_flat_rd).
- valid  out  1  sig is stable and unacknowledged (public_flat_rd).
- count  out  32  words acknowledged so far (public_flat_rd).
- done  out  1  count reached COUNT_MAX, sticky.
- err_proto  out  1  ack seen high in IDLE, sticky.
- err_timeout  out  1  ack not received within TIMEOUT cycles, sticky.

Behaviour:
- Reset values (asynchronous on reset_l=0):
  - state=IDLE, valid=0, count=0, done=0, err_proto=0, err_timeout=0, timer=0.
  - lfsr=SEED, or 1 if SEED==0.
  - sig=pattern(lfsr).
- Reset asserted mid-handshake aborts the transfer immediately; no partial count.
- pattern(s) is the 32-bit s replicated ceil(LENGTH/32) times, then truncated to LENGTH LSBs. sig is registered and only updated on LFSR advance.
- LFSR: 32-bit Galois, right shift, next = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0). It advances only on the ACKED→IDLE/PRESENT exit, never otherwise.
- State IDLE: valid=0.
  - enable=1 and done=0 → PRESENT next cycle; valid=1 from that cycle.
  - ack=1 sampled in IDLE → err_proto=1, state unchanged.
- State PRESENT: valid=1, timer increments per cycle, saturating.
  - ack=1 → ACKED next cycle: valid=0, count+1, timer cleared.
  - timer reaching TIMEOUT-1 with no ack → err_timeout=1. The block stays in PRESENT and still accepts a late ack.
- State ACKED: valid=0, waiting for ack=0.
  - On ack=0: advance the LFSR and update sig. Then:
    - count==COUNT_MAX → DONE.
    - else enable=1 → PRESENT.
    - else → IDLE.
  - sig must be stable before valid rises. The new sig is written in the same cycle the state moves to PRESENT, and valid asserts together with it. The host only samples sig while valid=1.
- State DONE: done=1, valid=0, terminal until reset; ack is ignored.
- Deasserting enable in PRESENT or ACKED does not abort the current word. It only blocks the next PRESENT.
- Simultaneous events: ack rising in the same cycle as the timeout limit → ack wins, err_timeout is not set.
- count is 32-bit and wraps modulo 2^32; not reachable with COUNT_MAX < 2^32.
- Latency: enable↑ to valid=1 is 1 cycle; ack↑ to valid=0 is 1 cycle; ack↓ to next valid=1 is 1 cycle when enable=1.

Decomposition:
- Shared package vpi_pkg holds:
  - state typedef enum {IDLE, PRESENT, ACKED, DONE} (2 bits).
  - LFSR_TAPS = 32'h8020_0003.
  - function lfsr_next().
- One natural sub-module: vpi_lfsr32 (state register, advance strobe, seed). The replication/truncation to LENGTH stays in the parent.

Test Plan:
- LENGTH=8, SEED=1: release reset, enable=1 → valid=1 after 1 cycle with sig=8'h01. ack=1 → valid=0, count=1. ack=0 → valid=1 with sig=8'h03.
- LENGTH=40, SEED=1: first sig=40'h01_0000_0001; after one transfer sig=40'h03_8020_0003.
- COUNT_MAX=3: complete 3 handshakes → done=1, valid stays 0; further ack pulses leave count=3 and err_proto=0.
- ack=1 with enable=0 in IDLE → err_proto=1 and stays set; then normal handshakes still work.
- TIMEOUT=10: enable, withhold ack 10 cycles → err_timeout=1. A late ack then completes with count=1.
- reset_l low while valid=1 → valid=0, count=0, sig=pattern(SEED) asynchronously. After release the sequence restarts from SEED.
